// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for the EX stage.
// Decodes the HI/LO funct codes, runs a WIDTH-cycle shift-add multiply or
// restoring divide, owns HI/LO and stalls colliding HI/LO accesses.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] mdout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI = 6'b010000;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;

  // Architectural and operation registers
  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;       // multiply: running upper half; divide: partial remainder
  logic [WIDTH-1:0] q;         // multiply: multiplier/low product; divide: dividend/quotient
  logic [WIDTH-1:0] mag_b;     // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_res;   // product/quotient sign
  logic             neg_rem;   // remainder follows the dividend sign
  logic             div_zero;

  // Decode: 0110xx starts an op, 0100xx is MFHI/MTHI/MFLO/MTLO
  logic is_start, is_mfmt, is_mt, is_hilo;
  assign is_start = (funct[5:2] == 4'b0110);
  assign is_mfmt  = (funct[5:2] == 4'b0100);
  assign is_mt    = is_mfmt & funct[0];
  assign is_hilo  = is_start | is_mfmt;

  // Read port: MFHI selects HI, everything else shows LO
  assign mdout = (en && funct == F_MFHI) ? hi : lo;

  // Operand magnitudes for the signed variants (funct[0]==0 is signed)
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sgn   = ~funct[0];
  assign sa    = sgn & srca[WIDTH-1];
  assign sb    = sgn & srcb[WIDTH-1];
  assign abs_a = sa ? -srca : srca;
  assign abs_b = sb ? -srcb : srcb;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = (state != IDLE) & en & is_hilo;
    done      = 1'b0;
    case (state)
      IDLE: if (en && is_start && !flush) state_nxt = RUN;
      RUN: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        done      = ~flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]   step_acc, mul_sum, div_sh;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH+1:0] div_diff;
  always_comb begin
    step_acc = acc;
    step_q   = q;
    mul_sum  = '0;
    div_sh   = '0;
    div_diff = '0;
    if (!is_div) begin
      mul_sum  = acc + (q[0] ? {1'b0, mag_b} : '0);
      step_acc = {1'b0, mul_sum[WIDTH:1]};
      step_q   = {mul_sum[0], q[WIDTH-1:1]};
    end else begin
      div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b00, mag_b};
      if (!div_diff[WIDTH+1]) begin
        step_acc = div_diff[WIDTH:0];
        step_q   = {q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_sh;
        step_q   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction of the finished result
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  always_comb begin
    prod   = {acc[WIDTH-1:0], q};
    prod_s = neg_res ? -prod : prod;
    quo    = div_zero ? '1 : (neg_res ? -q : q);
    rem    = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res_hi = is_div ? rem : prod_s[2*WIDTH-1:WIDTH];
    res_lo = is_div ? quo : prod_s[WIDTH-1:0];
  end

  // Datapath: operand latch, iteration, MT writes and result write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !flush) begin
            if (is_start) begin
              cnt      <= CW'(WIDTH - 1);
              acc      <= '0;
              q        <= abs_a;
              mag_b    <= abs_b;
              is_div   <= funct[1];
              neg_res  <= sa ^ sb;
              neg_rem  <= sa;
              div_zero <= (srcb == '0);
            end else if (is_mt) begin
              if (funct[1]) lo <= srca;
              else          hi <= srca;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= step_acc;
            q   <= step_q;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of complete operations
// followed by hand-written stall, flush, reset and MT/MF sequences.
module tb_muldiv_sequencer;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] ADD   = 6'b100000;

  logic        clk, reset, en, flush;
  logic [5:0]  funct;
  logic [31:0] srca, srcb, mdout;
  logic        busy, stall, done;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .en(en), .funct(funct), .srca(srca),
    .srcb(srcb), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .mdout(mdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Advance to just after the next rising edge (inputs are driven here)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] d);
    en = 1'b1; funct = f; srca = d;
    next_cycle();
    en = 1'b0; srca = '0;
  endtask

  task automatic rd(input logic [5:0] f, output logic [31:0] v);
    en = 1'b1; funct = f;
    @(negedge clk);
    v = mdout;
    next_cycle();
    en = 1'b0;
  endtask

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l, input string n);
    vec_t v;
    v.funct = f; v.a = a; v.b = b; v.hi = h; v.lo = l; v.name = n;
    return v;
  endfunction

  // Start in cycle 0, check busy/done over cycles 1..34, then read HI and LO
  task automatic run_vector(input vec_t v);
    logic        bad;
    logic [31:0] r;
    bad = 1'b0;
    en = 1'b1; funct = v.funct; srca = v.a; srcb = v.b;
    @(negedge clk);
    if (stall !== 1'b0) bad = 1'b1;
    next_cycle();
    en = 1'b0; srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad = 1'b1;
      if (done !== (cyc == 33)) bad = 1'b1;
      next_cycle();
    end
    en = 1'b1; funct = MFHI;
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    check({v.name, "_timing"}, {31'd0, bad}, 32'd0);
    check({v.name, "_hi"}, mdout, v.hi);
    next_cycle();
    rd(MFLO, r);
    check({v.name, "_lo"}, r, v.lo);
  endtask

  initial begin
    logic [31:0] r;
    logic        bad;
    int          nd;

    reset = 1'b1; en = 1'b0; flush = 1'b0; funct = '0; srca = '0; srcb = '0;

    vecs[0]  = mk(MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7x-3");
    vecs[1]  = mk(MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    vecs[2]  = mk(DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        "divu_100_7");
    vecs[3]  = mk(DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_-7_2");
    vecs[4]  = mk(DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_minneg_-1");
    vecs[5]  = mk(DIVU,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, "divu_by_zero");
    vecs[6]  = mk(DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by_zero");
    vecs[7]  = mk(MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_minneg_sq");
    vecs[8]  = mk(DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_-2");
    vecs[9]  = mk(MULTU, 32'h1234_5678,  32'd16,        32'd1,         32'h2345_6780, "multu_shift4");
    vecs[10] = mk(MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         "mult_-1x-1");
    vecs[11] = mk(DIVU,  32'hFFFF_FFFF,  32'd16,        32'd15,        32'h0FFF_FFFF, "divu_max_16");

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_lo", mdout, 32'd0);
    en = 1'b1; funct = MFHI;
    #1;
    check("reset_hi", mdout, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    en = 1'b0;
    reset = 1'b0;
    next_cycle();

    foreach (vecs[i]) run_vector(vecs[i]);

    // MFHI presented every cycle behind a MULT 7*(-3)
    en = 1'b1; funct = MULT; srca = 32'd7; srcb = 32'hFFFF_FFFD;
    next_cycle();
    funct = MFHI; srca = '0; srcb = '0;
    bad = 1'b0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      if (stall !== 1'b1) bad = 1'b1;
      next_cycle();
    end
    check("mfhi_stall_window", {31'd0, bad}, 32'd0);
    @(negedge clk);
    check("mfhi_stall_release", {31'd0, stall}, 32'd0);
    check("mfhi_new_value", mdout, 32'hFFFF_FFFF);
    next_cycle();
    en = 1'b0;

    // Flush during RUN of a DIV; ignored funct and stalled MTHI along the way
    mt(MTHI, 32'h11);
    mt(MTLO, 32'h22);
    en = 1'b1; funct = DIV; srca = 32'd100; srcb = 32'd7;
    next_cycle();
    en = 1'b0;
    nd = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5)  begin en = 1'b1; funct = ADD; end
      if (cyc == 6)  begin funct = MTHI; srca = 32'hDEAD; end
      if (cyc == 7)  en = 1'b0;
      if (cyc == 10) flush = 1'b1;
      if (cyc == 11) flush = 1'b0;
      @(negedge clk);
      if (cyc == 5)  check("ignored_funct_stall", {31'd0, stall}, 32'd0);
      if (cyc == 6)  check("busy_mthi_stall", {31'd0, stall}, 32'd1);
      if (cyc == 10) check("flush_busy_before", {31'd0, busy}, 32'd1);
      if (cyc == 11) check("flush_idle", {31'd0, busy}, 32'd0);
      if (done === 1'b1) nd++;
      next_cycle();
    end
    check("flush_no_done", nd, 32'd0);
    rd(MFHI, r);
    check("flush_hi_kept", r, 32'h11);
    rd(MFLO, r);
    check("flush_lo_kept", r, 32'h22);

    // Flush coinciding with FIX: no write, no done
    en = 1'b1; funct = MULT; srca = 32'd7; srcb = 32'd3;
    next_cycle();
    en = 1'b0;
    for (int cyc = 1; cyc <= 32; cyc++) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("fix_flush_busy", {31'd0, busy}, 32'd1);
    check("fix_flush_done", {31'd0, done}, 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("fix_flush_idle", {31'd0, busy}, 32'd0);
    next_cycle();
    rd(MFHI, r);
    check("fix_flush_hi", r, 32'h11);
    rd(MFLO, r);
    check("fix_flush_lo", r, 32'h22);

    // Flush in IDLE suppresses start and MT
    en = 1'b1; flush = 1'b1; funct = MULT; srca = 32'd2; srcb = 32'd3;
    next_cycle();
    funct = MTLO; srca = 32'h99;
    @(negedge clk);
    check("flush_idle_start", {31'd0, busy}, 32'd0);
    next_cycle();
    en = 1'b0; flush = 1'b0;
    rd(MFLO, r);
    check("flush_idle_mt", r, 32'h22);

    // Direct write and read back, default read port
    mt(MTLO, 32'hABCD);
    rd(MFLO, r);
    check("mtlo_mflo", r, 32'hABCD);
    mt(MTHI, 32'h55);
    @(negedge clk);
    check("mdout_default_lo", mdout, 32'hABCD);
    next_cycle();

    // Asynchronous reset in cycle 20 of a MULT
    en = 1'b1; funct = MULT; srca = 32'd7; srcb = 32'd3;
    next_cycle();
    en = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) next_cycle();
    #2 reset = 1'b1;
    #1;
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_lo", mdout, 32'd0);
    #2 reset = 1'b0;
    next_cycle();
    bad = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      next_cycle();
    end
    check("reset_mid_quiet", {31'd0, bad}, 32'd0);
    rd(MFHI, r);
    check("reset_mid_hi", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide execution unit and its sequencing controller for the EX stage of the pipelined MIPS core.
- Decodes the R-type HI/LO funct codes that the main ALU decoder does not handle, and runs 32-cycle shift-add multiply or restoring divide.
- Owns the HI/LO registers and stalls the pipeline whenever an HI/LO access collides with an operation in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  EX-stage instruction is a valid R-type HI/LO op; qualifies funct.
- funct  input  6  instruction funct field.
- srca  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- srcb  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  cancel the in-flight operation.
- busy  output  1  operation in progress (state != IDLE).
- stall  output  1  hold the pipeline; the current en op is not accepted.
- done  output  1  one-cycle pulse; the final result writes HI/LO at this cycle's closing edge.
- mdout  output  WIDTH  MFHI/MFLO read data, combinational from HI/LO.

Behaviour:
- Reset (async): state IDLE, HI=0, LO=0, counter=0, busy=0, stall=0, done=0.
- Funct decode:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 start an operation.
  - MFHI 010000, MFLO 010010 are reads; MTHI 010001, MTLO 010011 are writes.
  - Any other funct is ignored: no stall, no state change.
- States:
  - IDLE: with en and a start op, latch magnitudes, signs, op type and counter=WIDTH-1, then go to RUN.
  - RUN: perform one iteration per cycle. When counter==0 go to FIX; otherwise decrement.
  - FIX: apply sign correction, write HI/LO, assert done, go to IDLE.
- Timing:
  - Start sampled at the edge ending cycle 0.
  - RUN covers cycles 1..WIDTH; FIX is cycle WIDTH+1.
  - New HI/LO and busy=0 are visible from cycle WIDTH+2 (34 for WIDTH=32).
- Arithmetic:
  - Signed ops use the unsigned magnitudes of srca/srcb.
  - Multiply: 2*WIDTH product, HI=upper half, LO=lower half. Negate the product if the operand signs differ.
  - Divide: LO=quotient, HI=remainder. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - DIV of most-negative by -1 gives LO=0x80000000, HI=0 (falls out of magnitude arithmetic; no trap).
  - Divide by zero (DIV/DIVU): HI=srca as latched, LO=all ones. The full latency is still taken.
- Reads and writes while IDLE:
  - MFHI/MFLO: mdout=HI/LO the same cycle; stall=0.
  - MTHI/MTLO: HI/LO=srca at the next edge; stall=0.
  - When no read is active, mdout=LO.
- Stall rule: stall = busy & en & (funct is any of the 8 HI/LO ops).
  - The stalled op is not accepted; the pipeline re-presents it.
  - A stalled MFHI/MFLO is accepted in cycle WIDTH+2 and sees the new value.
  - No back-to-back start without one IDLE cycle in between.
- flush:
  - In RUN or FIX: go to IDLE at the next edge; HI/LO unchanged; done stays 0.
  - In IDLE: flush suppresses acceptance of a start or MT op in that cycle.
  - If flush and the FIX cycle coincide, flush wins: no write, no done.
- Reset mid-operation: immediate return to IDLE; HI/LO cleared; no done pulse.
- done is exactly one cycle per completed operation and is never asserted in IDLE or RUN.

Test Plan:
- MULT srca=7, srcb=0xFFFFFFFD:
  - busy=1 in cycles 1..33; done=1 in cycle 33.
  - From cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU with both operands 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU and DIV:
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF at cycle 34; done pulses once.
- MFHI presented every cycle from cycle 1 after MULT 7*(-3):
  - stall=1 in cycles 1..33, stall=0 in cycle 34.
  - mdout=0xFFFFFFFF in cycle 34.
- Cancellation and direct writes:
  - With HI=0x11, LO=0x22, flush in cycle 10 of a DIV -> idle at cycle 11, HI=0x11, LO=0x22, no done.
  - Reset at cycle 20 -> HI=LO=0, busy=0 asynchronously.
  - MTLO 0xABCD then MFLO -> mdout=0xABCD.
